// File: rtl/sha3_work_sequencer.sv
// Splits a nonce range into scanner-sized chunks, issues them one at a time and
// reports the first hit, an abort, or exhaustion of the range.
module sha3_work_sequencer #(
    parameter int INPUT_ELEMENTS = 20,
    parameter int NONCE_INDEX    = 19
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [32*INPUT_ELEMENTS-1:0]  job_blobby,
    input  logic [31:0]                   job_first,
    input  logic [31:0]                   job_last,
    input  logic                          abort,
    output logic                          scn_start,
    output logic [32*INPUT_ELEMENTS-1:0]  scn_blobby,
    input  logic                          scn_idle,
    input  logic                          scn_found,
    input  logic [31:0]                   scn_nonce,
    input  logic                          scn_evaluating,
    input  logic [31:0]                   scn_scan_count,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_found,
    output logic                          res_aborted,
    output logic [31:0]                   res_nonce,
    output logic [63:0]                   hash_count,
    output logic                          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_DONE,
        S_REPORT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic        abort_q, abort_d;
    logic        idle_q;
    logic [63:0] hash_q, hash_d;
    logic        res_found_q, res_found_d;
    logic        res_aborted_q, res_aborted_d;
    logic [31:0] res_nonce_q, res_nonce_d;
    logic [31:0] last_q;
    logic [31:0] step_q;
    logic [31:0] blob_q [INPUT_ELEMENTS];

    logic        accept;
    logic [32:0] next_base;
    logic [32:0] chunk_end;
    logic        exhausted;

    assign accept    = (state_q == S_IDLE) && job_valid;
    assign next_base = {1'b0, base_q} + {1'b0, step_q};
    assign chunk_end = next_base - 33'd1;
    // 33-bit arithmetic so a chunk touching 0xFFFF_FFFF ends the job instead of wrapping
    assign exhausted = (chunk_end >= {1'b0, last_q}) || next_base[32];

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        res_found_d   = res_found_q;
        res_aborted_d = res_aborted_q;
        res_nonce_d   = res_nonce_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    state_d = S_ISSUE;
                    base_d  = job_first;
                end
            end
            S_ISSUE: begin
                if (idle_q) begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!scn_idle) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (scn_idle) begin
                    if (scn_found) begin
                        state_d       = S_REPORT;
                        res_found_d   = 1'b1;
                        res_aborted_d = 1'b0;
                        res_nonce_d   = scn_nonce;
                    end else if (abort_q) begin
                        state_d       = S_REPORT;
                        res_found_d   = 1'b0;
                        res_aborted_d = 1'b1;
                        res_nonce_d   = 32'd0;
                    end else if (exhausted) begin
                        state_d       = S_REPORT;
                        res_found_d   = 1'b0;
                        res_aborted_d = 1'b0;
                        res_nonce_d   = 32'd0;
                    end else begin
                        state_d = S_ISSUE;
                        base_d  = next_base[31:0];
                    end
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        abort_d = abort_q;
        if (state_q == S_IDLE) begin
            if (job_valid) begin
                abort_d = 1'b0;
            end
        end else if (abort) begin
            abort_d = 1'b1;
        end
    end

    always_comb begin
        hash_d = hash_q;
        if (accept) begin
            hash_d = 64'd0;
        end else if ((state_q != S_IDLE) && scn_evaluating && (hash_q != {64{1'b1}})) begin
            hash_d = hash_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            base_q        <= 32'd0;
            abort_q       <= 1'b0;
            idle_q        <= 1'b0;
            hash_q        <= 64'd0;
            res_found_q   <= 1'b0;
            res_aborted_q <= 1'b0;
            res_nonce_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            abort_q       <= abort_d;
            idle_q        <= scn_idle;
            hash_q        <= hash_d;
            res_found_q   <= res_found_d;
            res_aborted_q <= res_aborted_d;
            res_nonce_q   <= res_nonce_d;
        end
    end

    // Job parameters need no reset: they are always written on accept before use
    always_ff @(posedge clk) begin
        if (accept) begin
            last_q <= job_last;
            step_q <= (scn_scan_count == 32'd0) ? 32'd1 : scn_scan_count;
            for (int i = 0; i < INPUT_ELEMENTS; i++) begin
                blob_q[i] <= job_blobby[32*i +: 32];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < INPUT_ELEMENTS; gi++) begin : g_blob
            if (gi == NONCE_INDEX) begin : g_nonce
                assign scn_blobby[32*gi +: 32] = base_q;
            end else begin : g_word
                assign scn_blobby[32*gi +: 32] = blob_q[gi];
            end
        end
    endgenerate

    // Start is driven from the registered idle sample, never straight from scn_idle
    assign scn_start   = (state_q == S_ISSUE) && idle_q;
    assign job_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_REPORT);
    assign res_found   = res_found_q;
    assign res_aborted = res_aborted_q;
    assign res_nonce   = res_nonce_q;
    assign hash_count  = hash_q;

endmodule

// File: doc/sha3_work_sequencer.md
SHA3_WORK_SEQUENCER -- requirements
Module: sha3_work_sequencer

Interface
REQ-001 SHALL have parameter INPUT_ELEMENTS, default 20: number of 32-bit words per work blob (24 for non-proper mode).
REQ-002 SHALL have parameter NONCE_INDEX, default 19: blob word replaced by the chunk base nonce.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port job_valid, input, 1: job offered.
REQ-006 SHALL have port job_ready, output, 1: sequencer accepts a job.
REQ-007 SHALL have port job_blobby, input, 32 x INPUT_ELEMENTS: blob template.
REQ-008 SHALL have port job_first, input, 32: first nonce of the range (inclusive).
REQ-009 SHALL have port job_last, input, 32: last nonce of the range (inclusive).
REQ-010 SHALL have port abort, input, 1: pulse that stops the job after the current chunk.
REQ-011 SHALL have port scn_start, output, 1: start strobe to the scanner.
REQ-012 SHALL have port scn_blobby, output, 32 x INPUT_ELEMENTS: blob to the scanner.
REQ-013 SHALL have port scn_idle, input, 1: scanner idle.
REQ-014 SHALL have port scn_found, input, 1: scanner result valid.
REQ-015 SHALL have port scn_nonce, input, 32: scanner result nonce.
REQ-016 SHALL have port scn_evaluating, input, 1: scanner testing a hash this cycle.
REQ-017 SHALL have port scn_scan_count, input, 32: constant nonces tested per chunk.
REQ-018 SHALL have port res_valid, output, 1: result available.
REQ-019 SHALL have port res_ready, input, 1: result consumed.
REQ-020 SHALL have port res_found, output, 1: a nonce met the threshold.
REQ-021 SHALL have port res_aborted, output, 1: job ended by abort.
REQ-022 SHALL have port res_nonce, output, 32: found nonce, else 0.
REQ-023 SHALL have port hash_count, output, 64: hashes evaluated in the current or last job.
REQ-024 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-025 SHALL implement states IDLE, ISSUE, WAIT_LOW, WAIT_DONE and REPORT.
REQ-026 In IDLE, job_ready=1 (combinational from state only); on job_valid the block SHALL latch blobby, first, last and step, set base=first, clear hash_count, clear the abort flag, and go to ISSUE.
REQ-027 The latched step SHALL be scn_scan_count sampled at job accept, with 0 treated as 1.
REQ-028 scn_blobby SHALL equal the latched blob with word NONCE_INDEX replaced by base, held stable from ISSUE through WAIT_DONE.
REQ-029 In ISSUE, while scn_idle=1, scn_start SHALL be 1 for exactly one cycle, then the block SHALL go to WAIT_LOW; while scn_idle=0 it SHALL hold in ISSUE with scn_start=0.
REQ-030 In WAIT_LOW it SHALL wait for scn_idle=0, then go to WAIT_DONE; scn_start SHALL be 0.
REQ-031 In WAIT_DONE, on scn_idle=1 it SHALL decide in that cycle, with priority, as REQ-032 to REQ-035.
REQ-032 Found: scn_found=1 -> REPORT with res_found=1 and res_nonce=scn_nonce.
REQ-033 Abort: abort flag set -> REPORT with res_aborted=1.
REQ-034 Exhausted: base+step-1 >= last, computed in 33 bits, or base+step > 0xFFFF_FFFF -> REPORT with found=0 and aborted=0.
REQ-035 Otherwise base += step (32-bit) and the block SHALL return to ISSUE.
REQ-036 abort SHALL be sampled in any non-IDLE state into a sticky flag; abort in IDLE SHALL be ignored; abort SHALL never cut a chunk short.
REQ-037 In REPORT, res_valid=1 and the res_* outputs SHALL be held stable until res_ready=1; res_valid and res_ready both 1 -> IDLE next cycle; res_valid SHALL be 0 in all other states.
REQ-038 hash_count SHALL increment by 1 each cycle scn_evaluating=1 in any non-IDLE state, SHALL saturate at 2^64-1, and SHALL hold its value in IDLE until the next accept.
REQ-039 A job with last < first SHALL still issue one chunk at first, then report exhausted.
REQ-040 Control decisions SHALL be registered; the path from scn_idle to scn_start SHALL be at least 1 cycle.

Reset
REQ-041 While rst=1 at a clk edge: state=IDLE, base=0, abort flag=0, hash_count=0, res_found=0, res_aborted=0, res_nonce=0; scn_start, res_valid and busy SHALL be 0; job_ready SHALL be 1.
REQ-042 Reset mid-job SHALL drop the job without a result; scn_start SHALL be 0 from the next cycle.

Verification
REQ-043 Exhausted: step=0x100, first=0, last=0x2FF, scanner never finds -> exactly 3 starts with word19 = 0x000, 0x100, 0x200; then res_valid, found=0, aborted=0.
REQ-044 Found: step=0x100, first=0x1000, last=0xFFFF, found on the 2nd chunk with nonce 0x1137 -> exactly 2 starts; res_found=1, res_nonce=0x1137.
REQ-045 Abort: abort pulsed during the 1st chunk, range 0..0xFFFF -> exactly 1 start; res_aborted=1, found=0; abort in IDLE -> no effect.
REQ-046 Wrap: first=0xFFFF_FF00, last=0xFFFF_FFFF, step=0x100 -> 1 start, then exhausted; base never wraps to 0.
REQ-047 Backpressure: res_ready held 0 for 10 cycles -> res_* stable and job_ready=0 throughout; IDLE the cycle after res_ready=1.
REQ-048 Reset in WAIT_DONE, then counting: rst=1 -> outputs per REQ-041 next cycle, no res_valid; a 2nd job with scn_evaluating high 50 cycles -> hash_count=50.
